// File: rtl/accum5_pkg.sv
// ---------------------------------------------------------------------------
// accum5_pkg
// Shared definitions for the accum_5 execute stage.
//   ACC_W                   : datapath width (fixed at 4 bits)
//   opcode_e                : 4-bit opcode set, OP_ADD (0) .. OP_ROR (15)
//   CMP_LT/EQ/GT_BIT        : bit positions of the CMP result flags
// Optional feature macro used by the design: ACCUM5_CIN_EN
// ---------------------------------------------------------------------------
package accum5_pkg;

  localparam int ACC_W = 4;

  // Result layout for CMP: {0, a>b, a==b, a<b}
  localparam int CMP_LT_BIT = 0;
  localparam int CMP_EQ_BIT = 1;
  localparam int CMP_GT_BIT = 2;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_CMP  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_NOT  = 4'd5,
    OP_INC  = 4'd6,
    OP_DEC  = 4'd7,
    OP_SHL0 = 4'd8,
    OP_SHL1 = 4'd9,
    OP_SHR0 = 4'd10,
    OP_SHR1 = 4'd11,
    OP_ASL  = 4'd12,
    OP_ASR  = 4'd13,
    OP_ROL  = 4'd14,
    OP_ROR  = 4'd15
  } opcode_e;

endpackage

// File: rtl/accum5_alu.sv
// ---------------------------------------------------------------------------
// accum5_alu
// Purely combinational 4-bit ALU core for accum_5.
// Ports:
//   a, b  (in, 4)  : operands; b only matters for ADD/SUB/CMP/AND/OR
//   cin   (in, 1)  : carry/borrow in, honoured by ADD/SUB only when
//                    ACCUM5_CIN_EN is defined, otherwise treated as 0
//   m     (in, 4)  : opcode (accum5_pkg::opcode_e encoding)
//   res   (out, 4) : result
//   flag  (out, 1) : carry / borrow / shifted-out / sign-change flag
// Configuration macro: ACCUM5_CIN_EN
// ---------------------------------------------------------------------------
module accum5_alu
  import accum5_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             cin,
  input  logic [3:0]       m,
  output logic [ACC_W-1:0] res,
  output logic             flag
);

  logic             w_cinEff;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W:0]   w_diff;
  logic [ACC_W:0]   w_inc;
  logic [ACC_W:0]   w_dec;
  opcode_e          w_op;

`ifdef ACCUM5_CIN_EN
  assign w_cinEff = cin;
`else
  // Carry-in disabled: the port stays for pin compatibility but is forced
  // to zero here so it has a defined (dead) load.
  assign w_cinEff = cin & 1'b0;
`endif

  // Extended-width arithmetic: bit ACC_W of the sum is the carry out, and
  // of the difference it is the borrow (the subtraction wraps negative).
  assign w_sum  = {1'b0, a} + {1'b0, b} + {{ACC_W{1'b0}}, w_cinEff};
  assign w_diff = {1'b0, a} - {1'b0, b} - {{ACC_W{1'b0}}, w_cinEff};
  assign w_inc  = {1'b0, a} + {{ACC_W{1'b0}}, 1'b1};
  assign w_dec  = {1'b0, a} - {{ACC_W{1'b0}}, 1'b1};

  assign w_op = opcode_e'(m);

  // Opcode decode; result and flag defaulted first so no path latches.
  always_comb begin
    res  = '0;
    flag = 1'b0;
    case (w_op)
      OP_ADD: begin
        res  = w_sum[ACC_W-1:0];
        flag = w_sum[ACC_W];
      end
      OP_SUB: begin
        res  = w_diff[ACC_W-1:0];
        flag = w_diff[ACC_W];
      end
      OP_CMP: begin
        res[CMP_GT_BIT] = (a > b);
        res[CMP_EQ_BIT] = (a == b);
        res[CMP_LT_BIT] = (a < b);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_NOT: res = ~a;
      OP_INC: begin
        res  = w_inc[ACC_W-1:0];
        flag = w_inc[ACC_W];
      end
      OP_DEC: begin
        res  = w_dec[ACC_W-1:0];
        flag = w_dec[ACC_W];
      end
      OP_SHL0: begin
        res  = {a[ACC_W-2:0], 1'b0};
        flag = a[ACC_W-1];
      end
      OP_SHL1: begin
        res  = {a[ACC_W-2:0], 1'b1};
        flag = a[ACC_W-1];
      end
      OP_SHR0: begin
        res  = {1'b0, a[ACC_W-1:1]};
        flag = a[0];
      end
      OP_SHR1: begin
        res  = {1'b1, a[ACC_W-1:1]};
        flag = a[0];
      end
      OP_ASL: begin
        // Flag marks a change of sign bit caused by the shift.
        res  = {a[ACC_W-2:0], 1'b0};
        flag = a[ACC_W-1] ^ a[ACC_W-2];
      end
      OP_ASR: begin
        res  = {a[ACC_W-1], a[ACC_W-1:1]};
        flag = a[0];
      end
      OP_ROL: begin
        res  = {a[ACC_W-2:0], a[ACC_W-1]};
        flag = a[ACC_W-1];
      end
      OP_ROR: begin
        res  = {a[0], a[ACC_W-1:1]};
        flag = a[0];
      end
      default: begin
        res  = '0;
        flag = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/accum_5.sv
// ---------------------------------------------------------------------------
// accum_5
// Registered 4-bit ALU execute stage: one-cycle latency, no feedback.
// Ports:
//   r      (out, 4) : registered result
//   of     (out, 1) : registered carry/borrow/shift-out flag
//   a, b   (in, 4)  : operands
//   cin    (in, 1)  : carry/borrow in (used only with ACCUM5_CIN_EN)
//   m      (in, 4)  : opcode from the controller
//   Clk    (in, 1)  : rising-edge clock
//   nReset (in, 1)  : synchronous reset, ACTIVE-HIGH despite the name
// Configuration macro: ACCUM5_CIN_EN (selects carry-in support in the ALU)
// ---------------------------------------------------------------------------
module accum_5
  import accum5_pkg::*;
(
  output logic [ACC_W-1:0] r,
  output logic             of,
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             cin,
  input  logic [3:0]       m,
  input  logic             Clk,
  input  logic             nReset
);

  logic [ACC_W-1:0] w_res;
  logic             w_flag;
  logic [ACC_W-1:0] r_res;
  logic             r_flag;

  accum5_alu u_alu (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .m    (m),
    .res  (w_res),
    .flag (w_flag)
  );

  // Output registers; reset wins over any opcode presented at the same edge.
  always_ff @(posedge Clk) begin
    if (nReset) begin
      r_res  <= '0;
      r_flag <= 1'b0;
    end else begin
      r_res  <= w_res;
      r_flag <= w_flag;
    end
  end

  assign r  = r_res;
  assign of = r_flag;

endmodule

// File: tb/tb_accum_5.sv
// ---------------------------------------------------------------------------
// tb_accum_5
// Self-checking bench for accum_5. Expected {r, of} values are queued when
// stimulus is driven and popped when the DUT result is sampled one edge
// later. Honours ACCUM5_CIN_EN for carry-in cases.
// ---------------------------------------------------------------------------
module tb_accum_5;

  logic [3:0] r;
  logic       of;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] m;
  logic       Clk;
  logic       nReset;

  typedef struct {
    logic [3:0] r;
    logic       f;
    string      name;
  } exp_t;

  exp_t sbq[$];
  int   nCompared   = 0;
  int   nMismatched = 0;

  accum_5 dut (
    .r      (r),
    .of     (of),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .m      (m),
    .Clk    (Clk),
    .nReset (nReset)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model written in integer arithmetic; returns {flag, result}.
  function automatic logic [4:0] model(input logic [3:0] ia, input logic [3:0] ib,
                                       input logic ic, input logic [3:0] im);
    int x, y, c, s, rr, ff;
    x = int'(ia);
    y = int'(ib);
`ifdef ACCUM5_CIN_EN
    c = int'(ic);
`else
    c = 0;
`endif
    rr = 0;
    ff = 0;
    case (int'(im))
      0:  begin s = x + y + c; rr = s % 16; ff = (s > 15) ? 1 : 0; end
      1:  begin s = x - y - c; rr = (s + 32) % 16; ff = (s < 0) ? 1 : 0; end
      2:  rr = ((x > y) ? 4 : 0) + ((x == y) ? 2 : 0) + ((x < y) ? 1 : 0);
      3:  rr = int'(ia & ib);
      4:  rr = int'(ia | ib);
      5:  rr = 15 - x;
      6:  begin rr = (x + 1) % 16; ff = (x == 15) ? 1 : 0; end
      7:  begin rr = (x + 15) % 16; ff = (x == 0) ? 1 : 0; end
      8:  begin rr = (x * 2) % 16; ff = x / 8; end
      9:  begin rr = (x * 2 + 1) % 16; ff = x / 8; end
      10: begin rr = x / 2; ff = x % 2; end
      11: begin rr = x / 2 + 8; ff = x % 2; end
      12: begin rr = (x * 2) % 16; ff = ((x / 8) != ((x % 8) / 4)) ? 1 : 0; end
      13: begin rr = x / 2 + ((x >= 8) ? 8 : 0); ff = x % 2; end
      14: begin rr = (x * 2) % 16 + x / 8; ff = x / 8; end
      default: begin rr = x / 2 + (x % 2) * 8; ff = x % 2; end
    endcase
    return {ff[0], rr[3:0]};
  endfunction

  // Drive one cycle of inputs and queue the result expected after the next edge.
  task automatic applyStimulus(input logic [3:0] ia, input logic [3:0] ib,
                               input logic ic, input logic [3:0] im,
                               input logic irst, input logic [3:0] er,
                               input logic ef, input string nm);
    exp_t e;
    a      = ia;
    b      = ib;
    cin    = ic;
    m      = im;
    nReset = irst;
    e.r    = er;
    e.f    = ef;
    e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) applyStimulus(4'b1111, 4'b0001, 1'b0, 4'd0, 1'b1, 4'b0000, 1'b0, "reset_hold");
      else       applyStimulus(4'b1111, 4'b0001, 1'b0, 4'd0, 1'b0, 4'b0000, 1'b1, "reset_release_add");
      @(posedge Clk); #1;
      e = sbq.pop_front();
      nCompared++;
      if (r !== e.r || of !== e.f) begin
        nMismatched++;
        $display("[TB] FAIL %s: got r=%b of=%b, want r=%b of=%b", e.name, r, of, e.r, e.f);
      end
    end
  endtask

  task automatic test_add_sub();
    exp_t e;
    logic [3:0] cinR;
    logic       cinF;
`ifdef ACCUM5_CIN_EN
    cinR = 4'b1000;
    cinF = 1'b0;
`else
    cinR = 4'b0111;
    cinF = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: applyStimulus(4'b1010, 4'b0101, 1'b0, 4'd0, 1'b0, 4'b1111, 1'b0, "add_1010_0101");
        1: applyStimulus(4'b0111, 4'b1100, 1'b0, 4'd1, 1'b0, 4'b1011, 1'b1, "sub_borrow");
        2: applyStimulus(4'b1111, 4'b1001, 1'b0, 4'd1, 1'b0, 4'b0110, 1'b0, "sub_noborrow");
        default: applyStimulus(4'b0011, 4'b0100, 1'b1, 4'd0, 1'b0, cinR, cinF, "add_cin");
      endcase
      @(posedge Clk); #1;
      e = sbq.pop_front();
      nCompared++;
      if (r !== e.r || of !== e.f) begin
        nMismatched++;
        $display("[TB] FAIL %s: got r=%b of=%b, want r=%b of=%b", e.name, r, of, e.r, e.f);
      end
    end
  endtask

  task automatic test_cmp_logic();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: applyStimulus(4'b1001, 4'b0001, 1'b0, 4'd2, 1'b0, 4'b0100, 1'b0, "cmp_gt");
        1: applyStimulus(4'b0011, 4'b0011, 1'b1, 4'd2, 1'b0, 4'b0010, 1'b0, "cmp_eq");
        2: applyStimulus(4'b0001, 4'b1000, 1'b0, 4'd2, 1'b0, 4'b0001, 1'b0, "cmp_lt");
        3: applyStimulus(4'b0111, 4'b1100, 1'b0, 4'd3, 1'b0, 4'b0100, 1'b0, "and");
        4: applyStimulus(4'b0111, 4'b1100, 1'b0, 4'd4, 1'b0, 4'b1111, 1'b0, "or");
        default: applyStimulus(4'b1010, 4'b0110, 1'b1, 4'd5, 1'b0, 4'b0101, 1'b0, "not");
      endcase
      @(posedge Clk); #1;
      e = sbq.pop_front();
      nCompared++;
      if (r !== e.r || of !== e.f) begin
        nMismatched++;
        $display("[TB] FAIL %s: got r=%b of=%b, want r=%b of=%b", e.name, r, of, e.r, e.f);
      end
    end
  endtask

  task automatic test_inc_dec();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: applyStimulus(4'b1111, 4'b0000, 1'b0, 4'd6, 1'b0, 4'b0000, 1'b1, "inc_wrap");
        1: applyStimulus(4'b0000, 4'b0000, 1'b0, 4'd7, 1'b0, 4'b1111, 1'b1, "dec_wrap");
        default: applyStimulus(4'b1001, 4'b0000, 1'b0, 4'd7, 1'b0, 4'b1000, 1'b0, "dec_plain");
      endcase
      @(posedge Clk); #1;
      e = sbq.pop_front();
      nCompared++;
      if (r !== e.r || of !== e.f) begin
        nMismatched++;
        $display("[TB] FAIL %s: got r=%b of=%b, want r=%b of=%b", e.name, r, of, e.r, e.f);
      end
    end
  endtask

  task automatic test_shifts();
    exp_t e;
    logic [3:0] expR [8];
    logic       expF [8];
    expR = '{4'b0010, 4'b0011, 4'b0100, 4'b1100, 4'b0010, 4'b1100, 4'b0011, 4'b1100};
    expF = '{1'b1,    1'b1,    1'b1,    1'b1,    1'b1,    1'b1,    1'b1,    1'b1};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b1001, 4'b1111, 1'b1, 4'(8 + i), 1'b0, expR[i], expF[i],
                    $sformatf("shift_m%0d", 8 + i));
      @(posedge Clk); #1;
      e = sbq.pop_front();
      nCompared++;
      if (r !== e.r || of !== e.f) begin
        nMismatched++;
        $display("[TB] FAIL %s: got r=%b of=%b, want r=%b of=%b", e.name, r, of, e.r, e.f);
      end
    end
    // ASL with no sign change must leave the flag clear.
    applyStimulus(4'b0101, 4'b0000, 1'b0, 4'd12, 1'b0, 4'b1010, 1'b1, "asl_signchg");
    @(posedge Clk); #1;
    e = sbq.pop_front();
    nCompared++;
    if (r !== e.r || of !== e.f) begin
      nMismatched++;
      $display("[TB] FAIL %s: got r=%b of=%b, want r=%b of=%b", e.name, r, of, e.r, e.f);
    end
    applyStimulus(4'b1101, 4'b0000, 1'b0, 4'd12, 1'b0, 4'b1010, 1'b0, "asl_nosignchg");
    @(posedge Clk); #1;
    e = sbq.pop_front();
    nCompared++;
    if (r !== e.r || of !== e.f) begin
      nMismatched++;
      $display("[TB] FAIL %s: got r=%b of=%b, want r=%b of=%b", e.name, r, of, e.r, e.f);
    end
  endtask

  // Inputs change every cycle; each result must land exactly one edge later.
  // A reset is injected mid-stream with an ADD pending.
  task automatic test_back_to_back();
    exp_t       e;
    logic [3:0] ra, rb, rm;
    logic       rc, rst;
    logic [4:0] mv;
    for (int i = 0; i < 40; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rc  = 1'($urandom_range(0, 1));
      rm  = 4'($urandom_range(0, 15));
      rst = 1'b0;
      if (i == 20) begin
        ra  = 4'b1111;
        rb  = 4'b1111;
        rm  = 4'd0;
        rst = 1'b1;
      end
      mv = model(ra, rb, rc, rm);
      if (rst) applyStimulus(ra, rb, rc, rm, 1'b1, 4'b0000, 1'b0, "midstream_reset");
      else     applyStimulus(ra, rb, rc, rm, 1'b0, mv[3:0], mv[4],
                             $sformatf("b2b_%0d_m%0d", i, rm));
      @(posedge Clk); #1;
      e = sbq.pop_front();
      nCompared++;
      if (r !== e.r || of !== e.f) begin
        nMismatched++;
        $display("[TB] FAIL %s: got r=%b of=%b, want r=%b of=%b", e.name, r, of, e.r, e.f);
      end
    end
  endtask

  initial begin
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    m      = '0;
    nReset = 1'b1;
    @(negedge Clk);
    test_reset();
    test_add_sub();
    test_cmp_logic();
    test_inc_dec();
    test_shifts();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
